can_rx_fifo: RTL and testbench
==============================

# can_rx_fifo

Receive-side frame buffer between the CAN bit-level receiver and the host read port. It accepts a byte stream per frame from the receiver, holds the bytes speculatively until the frame is confirmed, and exposes only confirmed frames on a valid/ready byte stream with an end-of-frame marker. Frames that are aborted by the receiver or overflow the buffer are discarded whole and counted.

## Interface
- AWIDTH, 10: RAM address width; usable capacity is 2^AWIDTH−1 bytes.
- DWIDTH, 8: data byte width.
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ivalid  in  1  receiver byte strobe; no back-pressure on this side.
- idata  in  DWIDTH  received byte.
- ilast  in  1  qualifies ivalid; marks the final data byte of the frame.
- icommit  in  1  single-cycle pulse: frame passed CRC/EOF, publish it.
- iabort  in  1  single-cycle pulse: frame errored, discard it.
- emptyn  out  1  at least one committed byte not yet fetched from RAM.
- otvalid  out  1  output byte valid.
- otready  in  1  consumer accepts byte.
- otdata  out  DWIDTH  output byte.
- otlast  out  1  output byte is last of its frame.
- drop_cnt  out  8  frames discarded due to overflow or protocol error, saturates at 255.

## Operation
- Pointers: rpt (read), wpt (committed write), wtmp (speculative write). RAM is DWIDTH+1 wide: {last, data}.
- Write: ivalid & ~ferr & ~fdone & (wtmp+1 != rpt) → RAM[wtmp] <= {ilast, idata}, wtmp+1. If ilast, set fdone.
- Overflow: ivalid while wtmp+1 == rpt → byte not written, set ferr.
- Protocol error: ivalid while fdone=1 (bytes after ilast) → set ferr, byte not written.
- Commit: icommit & ~ferr & fdone → wpt <= wtmp (including a byte written the same cycle). icommit with ferr=1 or fdone=0 → treated as abort, drop_cnt+1 (saturating).
- Abort: iabort → wtmp <= wpt; no count unless ferr=1 (then drop_cnt+1). icommit and iabort in the same cycle: abort wins.
- Commit or abort clears ferr and fdone for the next frame.
- Read side: prefetch from RAM[rpt] whenever wpt != rpt and (otready | ~otvalid); one-entry holding register keeps otdata/otlast stable while otvalid & ~otready. Bytes are never read beyond wpt.
- Transfer occurs on otvalid & otready. Frame order and byte order preserved.
- Pointers wrap modulo 2^AWIDTH; wtmp may never equal rpt after an increment (one slot kept empty).

## Timing
- Reset: otvalid=0, otdata=0, otlast=0, emptyn=0, drop_cnt=0, all pointers 0, ferr=fdone=0. Reset mid-frame discards all contents, including committed frames, without counting.
- icommit sampled in cycle t → emptyn high in t+1 → otvalid first high in t+2.
- Sustained throughput 1 byte/cycle with otready held high.
- otvalid & ~otready: otdata/otlast held unchanged until accepted.
- drop_cnt updates the cycle after the discarding commit/abort.
- Write port never stalls; a write and a read to the same RAM address cannot collide because wtmp never reaches rpt.

## Structure
- Shared package can_pkg: CAN_DWIDTH=8, default FIFO AWIDTH, drop-counter width, saturation constant.
- Reuse the existing sync_ram sub-module (instantiated with DWIDTH+1) for storage; pointer/commit logic and output skid register stay in can_rx_fifo.

## Test plan
- Single frame: 8 bytes 0x01..0x08, ilast on 0x08, icommit 3 cycles later, otready=1 → otvalid two cycles after icommit, bytes 0x01..0x08, otlast only on 0x08, drop_cnt=0.
- Abort: 5 bytes then iabort, then 2-byte frame 0xAA,0xBB committed → only 0xAA,0xBB emerge; drop_cnt=0; aborted bytes never visible.
- Overflow: AWIDTH=4, otready=0, 20-byte frame committed → frame dropped, drop_cnt=1, emptyn=0; next 3-byte frame delivered intact.
- Back-pressure: 4-byte frame, toggle otready 1/0 each cycle → each byte held stable while otready=0, all 4 delivered in order, otlast on byte 4.
- Same-cycle events: last byte with icommit in same cycle → frame delivered; icommit+iabort together → frame discarded, drop_cnt unchanged.
- Wrap and saturation: stream 300 error frames (icommit without ilast) plus frames crossing address 2^AWIDTH−1 → drop_cnt=255 holds, wrapping frames delivered correctly; rst asserted mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/can_pkg.sv
// can_pkg: shared widths and drop-counter constants for the CAN receive path
package can_pkg;
  localparam int CAN_DWIDTH = 8;
  localparam int CAN_AWIDTH = 10;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return v == DROP_MAX ? v : v + DROP_W'(1);
  endfunction
endpackage

// File: rtl/sync_ram.sv
// sync_ram: simple dual-port RAM, one write port, one registered read port
//   clk            clock
//   we/waddr/wdata write strobe, address, data
//   re/raddr       read strobe and address; q updates only when re is high
//   q              registered read data, held between reads
module sync_ram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] q
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/can_rx_fifo.sv
// can_rx_fifo: speculative receive frame buffer publishing only committed CAN frames
//   clk, rst                      clock, synchronous active-high reset
//   ivalid/idata/ilast            receiver byte stream (no back-pressure)
//   icommit/iabort                frame confirm / discard pulses
//   emptyn                        committed bytes remain unfetched in RAM
//   otvalid/otready/otdata/otlast host byte stream with end-of-frame marker
//   drop_cnt                      saturating count of discarded frames
module can_rx_fifo import can_pkg::*; #(
  parameter int AWIDTH = CAN_AWIDTH,
  parameter int DWIDTH = CAN_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ivalid,
  input  logic [DWIDTH-1:0] idata,
  input  logic              ilast,
  input  logic              icommit,
  input  logic              iabort,
  output logic              emptyn,
  output logic              otvalid,
  input  logic              otready,
  output logic [DWIDTH-1:0] otdata,
  output logic              otlast,
  output logic [DROP_W-1:0] drop_cnt
);
  logic [AWIDTH-1:0] rpt, wpt, wtmp, wnext, wtmp_n;
  logic ferr, fdone, ferr_n, fdone_n, wr, rd, publish, drop, close;
  logic [DWIDTH:0] q;
  always_comb begin
    wnext = wtmp + AWIDTH'(1);
    wr = ivalid & ~ferr & ~fdone & (wnext != rpt);
    ferr_n = ferr | (ivalid & (fdone | (wnext == rpt)));
    fdone_n = fdone | (wr & ilast);
    wtmp_n = wr ? wnext : wtmp;
    close = icommit | iabort;
    // a last byte arriving with icommit still counts toward the publish decision
    publish = icommit & ~iabort & ~ferr_n & fdone_n;
    drop = iabort ? ferr_n : icommit & ~publish;
    rd = (wpt != rpt) & (otready | ~otvalid);
  end
  sync_ram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH + 1)) u_ram (
    .clk(clk), .we(wr), .waddr(wtmp), .wdata({ilast, idata}),
    .re(rd), .raddr(rpt), .q(q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt <= '0;
      wpt <= '0;
      wtmp <= '0;
      ferr <= 1'b0;
      fdone <= 1'b0;
      otvalid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rpt <= rd ? rpt + AWIDTH'(1) : rpt;
      wpt <= publish ? wtmp_n : wpt;
      wtmp <= close & ~publish ? wpt : wtmp_n;
      ferr <= ~close & ferr_n;
      fdone <= ~close & fdone_n;
      otvalid <= rd | (otvalid & ~otready);
      drop_cnt <= drop ? sat_inc(drop_cnt) : drop_cnt;
    end
  end
  // RAM output register only reloads on rd, so it doubles as the holding register
  assign emptyn = wpt != rpt;
  assign otdata = otvalid ? q[DWIDTH-1:0] : '0;
  assign otlast = otvalid & q[DWIDTH];
endmodule

// File: tb/tb_can_rx_fifo.sv
// tb_can_rx_fifo: scoreboard bench for can_rx_fifo with directed frame scenarios
module tb_can_rx_fifo;
  logic clk = 0, rst = 1;
  logic ivalid = 0, ilast = 0, icommit = 0, iabort = 0, otready = 0;
  logic [7:0] idata = 0;
  logic emptyn, otvalid, otlast;
  logic [7:0] otdata, drop_cnt;
  int tests = 0, fails = 0;
  logic [8:0] exp_q[$];
  logic hold = 0;
  logic [8:0] held;

  always #5 clk = ~clk;

  can_rx_fifo #(.AWIDTH(4), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata), .ilast(ilast),
    .icommit(icommit), .iabort(iabort), .emptyn(emptyn), .otvalid(otvalid),
    .otready(otready), .otdata(otdata), .otlast(otlast), .drop_cnt(drop_cnt)
  );

  always @(negedge clk) begin
    if (rst) hold = 0;
    else begin
      if (hold) begin
        tests++;
        if (!otvalid || {otlast, otdata} != held) begin
          fails++;
          $display("FAIL hold: got v=%0b %h, need v=1 %h", otvalid, {otlast, otdata}, held);
        end
      end
      if (otvalid && otready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected byte: got %h, need none", {otlast, otdata});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({otlast, otdata} != e) begin
            fails++;
            $display("FAIL byte: got last=%0b data=%h, need last=%0b data=%h", otlast, otdata, e[8], e[7:0]);
          end
        end
      end
      hold = otvalid && !otready;
      held = {otlast, otdata};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic c);
    ivalid = 1; idata = d; ilast = l; icommit = c;
    step();
    ivalid = 0; ilast = 0; icommit = 0;
  endtask

  task automatic commit();
    icommit = 1;
    step();
    icommit = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    step(); step();
    rst = 0;
    chk("reset otvalid", otvalid, 0);
    chk("reset otdata", otdata, 0);
    chk("reset otlast", otlast, 0);
    chk("reset emptyn", emptyn, 0);
    chk("reset drop_cnt", drop_cnt, 0);

    // single frame with latency check
    otready = 1;
    for (int i = 1; i <= 8; i++) exp_q.push_back({i == 8, 8'(i)});
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8, 0);
    step(); step();
    chk("pre-commit emptyn", emptyn, 0);
    commit();
    chk("emptyn t+1", emptyn, 1);
    chk("otvalid t+1", otvalid, 0);
    step();
    chk("otvalid t+2", otvalid, 1);
    drain("single frame drained");
    chk("single drop_cnt", drop_cnt, 0);

    // abort then a good frame
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 0, 0);
    iabort = 1; step(); iabort = 0;
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hBB});
    send(8'hAA, 0, 0);
    send(8'hBB, 1, 0);
    commit();
    drain("abort frame drained");
    chk("abort drop_cnt", drop_cnt, 0);

    // overflow: 20 bytes into 15 slots with consumer stalled
    otready = 0;
    for (int i = 1; i <= 20; i++) send(8'(i), i == 20, 0);
    commit();
    chk("overflow drop_cnt", drop_cnt, 1);
    step();
    chk("overflow emptyn", emptyn, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back({i == 2, 8'hC0 + 8'(i)});
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), i == 2, 0);
    commit();
    step(); step(); step();
    chk("stalled otvalid", otvalid, 1);
    otready = 1;
    drain("post-overflow drained");

    // back-pressure toggling
    otready = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'hD0 + 8'(i)});
    for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), i == 3, 0);
    commit();
    for (int i = 0; i < 16; i++) begin otready = ~otready; step(); end
    otready = 1;
    drain("backpressure drained");

    // last byte with commit in the same cycle
    exp_q.push_back({1'b0, 8'hE1});
    exp_q.push_back({1'b1, 8'hE2});
    send(8'hE1, 0, 0);
    send(8'hE2, 1, 1);
    drain("same-cycle commit drained");

    // commit and abort together discards without counting
    send(8'hF1, 0, 0);
    send(8'hF2, 1, 0);
    icommit = 1; iabort = 1; step(); icommit = 0; iabort = 0;
    step(); step();
    chk("commit+abort emptyn", emptyn, 0);
    chk("commit+abort drop_cnt", drop_cnt, 1);

    // frames wrapping the 16-entry address space
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, 8'h40 + 8'(f * 5 + i)});
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 5; i++) send(8'h40 + 8'(f * 5 + i), i == 4, i == 4);
    drain("wrap frames drained");

    // error frames drive the counter into saturation
    for (int i = 0; i < 200; i++) send(8'hFF, 0, 1);
    chk("drop_cnt 201", drop_cnt, 201);
    for (int i = 0; i < 100; i++) send(8'hFF, 0, 1);
    chk("drop_cnt saturated", drop_cnt, 255);
    send(8'h01, 0, 0);
    send(8'h02, 0, 0);
    send(8'h03, 0, 0);
    send(8'h04, 1, 0);
    send(8'h05, 0, 0);
    iabort = 1; step(); iabort = 0;
    chk("drop_cnt holds", drop_cnt, 255);
    exp_q.push_back({1'b1, 8'h77});
    send(8'h77, 1, 1);
    drain("post-saturation drained");

    // reset mid-frame discards everything
    otready = 0;
    send(8'h90, 0, 0);
    send(8'h91, 1, 1);
    step(); step(); step();
    chk("pre-reset otvalid", otvalid, 1);
    send(8'h92, 0, 0);
    ivalid = 1; idata = 8'h93;
    rst = 1;
    step();
    ivalid = 0;
    chk("mid reset otvalid", otvalid, 0);
    chk("mid reset otdata", otdata, 0);
    chk("mid reset otlast", otlast, 0);
    chk("mid reset emptyn", emptyn, 0);
    chk("mid reset drop_cnt", drop_cnt, 0);
    rst = 0;
    otready = 1;
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b1, 8'h5B});
    send(8'h5A, 0, 0);
    send(8'h5B, 1, 1);
    drain("post-reset drained");
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
